// File: rtl/lsb_mem_responder.sv
// Data-side memory responder for the load/store buffer request port.
// Serialises one load or store onto the byte-wide RAM bus (1-cycle read latency)
// and returns a one-cycle completion pulse with extended load data.
// Optional build macro LSB_MEM_IO_STALL_EN: stall IO-region store bytes while the
// IO sink reports io_buffer_full.
module lsb_mem_responder #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned IO_SEL_LO  = 16,
    parameter logic [1:0]  IO_SEL_VAL = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              lsb_flag,
    input  logic              lsb_r_nw,
    input  logic              load_sign,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_write,
    input  logic              flush,
    input  logic              bus_grant,
    input  logic              io_buffer_full,
    output logic              lsb_enable,
    output logic              data_rdy,
    output logic [31:0]       data_read,
    output logic              bus_req,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    output logic              mem_wr,
    input  logic [7:0]        mem_din
);

    typedef enum logic [2:0] {StIdle, StWaitBus, StRead, StWrite, StDone} state_e;

    state_e            state_q;
    logic [2:0]        cnt_q;       // byte index k of the current bus cycle
    logic [2:0]        nbytes_q;    // N = 1, 2 or 4
    logic              r_nw_q;
    logic              sign_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;

    logic              lsb_enable_q;
    logic              data_rdy_q;
    logic [31:0]       data_read_q;
    logic              bus_req_q;
    logic [ADDR_W-1:0] mem_a_q;
    logic [7:0]        mem_dout_q;
    logic              mem_wr_q;

    logic [2:0]        cnt_inc;
    logic [1:0]        lane;
    logic [ADDR_W-1:0] next_addr;
    logic [7:0]        next_byte;
    logic [31:0]       ext_data;
    logic              is_io;
    logic              io_stall;

    assign cnt_inc   = cnt_q + 3'd1;
    // Read data for index k arrives one cycle late, so it lands in lane k-1.
    assign lane      = cnt_q[1:0] - 2'd1;
    assign next_addr = addr_q + ADDR_W'(cnt_inc);
    assign next_byte = wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
    assign is_io     = (addr_q[IO_SEL_LO +: 2] == IO_SEL_VAL);

`ifdef LSB_MEM_IO_STALL_EN
    assign io_stall = (state_q == StWrite) && is_io && io_buffer_full;
`else
    logic unused_io;
    assign unused_io = io_buffer_full & is_io;
    assign io_stall  = 1'b0;
`endif

    // Sign/zero extension of the assembled load bytes from bit 8N-1.
    always_comb begin
        ext_data = rdata_q;
        case (nbytes_q)
            3'd1:    ext_data = {{24{sign_q & rdata_q[7]}}, rdata_q[7:0]};
            3'd2:    ext_data = {{16{sign_q & rdata_q[15]}}, rdata_q[15:0]};
            default: ext_data = rdata_q;
        endcase
    end

    // Request/transfer state machine with registered bus and completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            nbytes_q     <= '0;
            r_nw_q       <= 1'b0;
            sign_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            lsb_enable_q <= 1'b1;
            data_rdy_q   <= 1'b0;
            data_read_q  <= '0;
            bus_req_q    <= 1'b0;
            mem_a_q      <= '0;
            mem_dout_q   <= '0;
            mem_wr_q     <= 1'b0;
        end else if (rdy) begin
            data_rdy_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (lsb_flag && !flush) begin
                        r_nw_q       <= lsb_r_nw;
                        sign_q       <= load_sign;
                        addr_q       <= data_addr;
                        wdata_q      <= data_write;
                        rdata_q      <= '0;
                        cnt_q        <= '0;
                        nbytes_q     <= (data_size == 2'd0) ? 3'd1 :
                                        (data_size == 2'd1) ? 3'd2 : 3'd4;
                        bus_req_q    <= 1'b1;
                        lsb_enable_q <= 1'b0;
                        state_q      <= StWaitBus;
                    end
                end
                StWaitBus: begin
                    if (flush) begin
                        bus_req_q    <= 1'b0;
                        lsb_enable_q <= 1'b1;
                        state_q      <= StIdle;
                    end else if (bus_grant) begin
                        cnt_q   <= '0;
                        mem_a_q <= addr_q;
                        if (r_nw_q) begin
                            state_q <= StRead;
                        end else begin
                            mem_dout_q <= wdata_q[7:0];
                            mem_wr_q   <= 1'b1;
                            state_q    <= StWrite;
                        end
                    end
                end
                StRead: begin
                    if (flush) begin
                        bus_req_q    <= 1'b0;
                        lsb_enable_q <= 1'b1;
                        state_q      <= StIdle;
                    end else begin
                        if (cnt_q != 3'd0) begin
                            rdata_q[{lane, 3'b000} +: 8] <= mem_din;
                        end
                        if (cnt_q == nbytes_q) begin
                            state_q <= StDone;
                        end else begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc < nbytes_q) begin
                                mem_a_q <= next_addr;
                            end
                        end
                    end
                end
                StWrite: begin
                    // Committed stores ignore flush; a stalled IO byte holds k.
                    if (!io_stall) begin
                        if (cnt_inc == nbytes_q) begin
                            mem_wr_q <= 1'b0;
                            state_q  <= StDone;
                        end else begin
                            cnt_q      <= cnt_inc;
                            mem_a_q    <= next_addr;
                            mem_dout_q <= next_byte;
                        end
                    end
                end
                StDone: begin
                    data_rdy_q   <= 1'b1;
                    data_read_q  <= r_nw_q ? ext_data : 32'd0;
                    bus_req_q    <= 1'b0;
                    lsb_enable_q <= 1'b1;
                    state_q      <= StIdle;
                end
                default: begin
                    mem_wr_q     <= 1'b0;
                    bus_req_q    <= 1'b0;
                    lsb_enable_q <= 1'b1;
                    state_q      <= StIdle;
                end
            endcase
        end
    end

    assign lsb_enable = lsb_enable_q;
    assign data_rdy   = data_rdy_q;
    assign data_read  = data_read_q;
    assign bus_req    = bus_req_q;
    assign mem_a      = mem_a_q;
    assign mem_dout   = mem_dout_q;
    // Write strobe is suppressed immediately by a freeze or an IO stall.
    assign mem_wr     = mem_wr_q & rdy & ~io_stall;

endmodule

// File: tb/tb_lsb_mem_responder.sv
// Directed self-checking bench for lsb_mem_responder.
module tb_lsb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        lsb_flag = 1'b0;
    logic        lsb_r_nw = 1'b0;
    logic        load_sign = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_write = '0;
    logic        flush = 1'b0;
    logic        bus_grant = 1'b1;
    logic        io_buffer_full = 1'b0;
    logic        lsb_enable;
    logic        data_rdy;
    logic [31:0] data_read;
    logic        bus_req;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din = '0;

    int total = 0;
    int bad = 0;

    // Write log and completion-pulse counter, filled by the bus model.
    logic [31:0] wlog_a [0:63];
    logic [7:0]  wlog_d [0:63];
    int          wr_n = 0;
    int          rdy_pulses = 0;

    lsb_mem_responder #(
        .ADDR_W    (32),
        .IO_SEL_LO (16),
        .IO_SEL_VAL(2'b11)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .lsb_flag      (lsb_flag),
        .lsb_r_nw      (lsb_r_nw),
        .load_sign     (load_sign),
        .data_size     (data_size),
        .data_addr     (data_addr),
        .data_write    (data_write),
        .flush         (flush),
        .bus_grant     (bus_grant),
        .io_buffer_full(io_buffer_full),
        .lsb_enable    (lsb_enable),
        .data_rdy      (data_rdy),
        .data_read     (data_read),
        .bus_req       (bus_req),
        .mem_a         (mem_a),
        .mem_dout      (mem_dout),
        .mem_wr        (mem_wr),
        .mem_din       (mem_din)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h100: rom = 8'h11;
            32'h101: rom = 8'h22;
            32'h102: rom = 8'h33;
            32'h103: rom = 8'h84;
            32'h180: rom = 8'h80;
            default: rom = a[7:0];
        endcase
    endfunction

    // RAM model: 1-cycle read latency, writes logged.
    always @(posedge clk) begin
        mem_din <= rom(mem_a);
        if (mem_wr) begin
            wlog_a[wr_n[5:0]] <= mem_a;
            wlog_d[wr_n[5:0]] <= mem_dout;
            wr_n <= wr_n + 1;
        end
    end

    always @(negedge clk) begin
        if (data_rdy) rdy_pulses <= rdy_pulses + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic rnw, input logic sgn, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd);
        lsb_r_nw   = rnw;
        load_sign  = sgn;
        data_size  = sz;
        data_addr  = a;
        data_write = wd;
        lsb_flag   = 1'b1;
        step();
        lsb_flag   = 1'b0;
    endtask

    // Steps until data_rdy is seen; cyc saturates at 30 on timeout.
    task automatic wait_rdy(output int cyc);
        cyc = 0;
        while (!data_rdy && cyc < 30) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total++; if (lsb_enable !== 1'b1) begin bad++; $display("FAIL reset_lsb_enable got %b want 1", lsb_enable); end
        total++; if (data_rdy !== 1'b0) begin bad++; $display("FAIL reset_data_rdy got %b want 0", data_rdy); end
        total++; if (data_read !== 32'h0) begin bad++; $display("FAIL reset_data_read got %h want 0", data_read); end
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL reset_bus_req got %b want 0", bus_req); end
        total++; if (mem_a !== 32'h0) begin bad++; $display("FAIL reset_mem_a got %h want 0", mem_a); end
        total++; if (mem_dout !== 8'h0) begin bad++; $display("FAIL reset_mem_dout got %h want 0", mem_dout); end
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL reset_mem_wr got %b want 0", mem_wr); end
    endtask

    task automatic test_lw();
        int cyc;
        do_req(1'b1, 1'b0, 2'd3, 32'h100, 32'h0);
        total++; if (bus_req !== 1'b1 || lsb_enable !== 1'b0) begin bad++; $display("FAIL lw_req got bus_req=%b en=%b want 1 0", bus_req, lsb_enable); end
        for (int k = 0; k < 4; k++) begin
            step();
            total++; if (mem_a !== 32'h100 + k || mem_wr !== 1'b0) begin bad++; $display("FAIL lw_mem_a k=%0d got %h wr=%b want %h wr=0", k, mem_a, mem_wr, 32'h100 + k); end
        end
        wait_rdy(cyc);
        total++; if (cyc !== 3) begin bad++; $display("FAIL lw_latency got %0d want 7", cyc + 4); end
        total++; if (data_read !== 32'h84332211) begin bad++; $display("FAIL lw_data got %h want 84332211", data_read); end
        total++; if (lsb_enable !== 1'b1 || bus_req !== 1'b0) begin bad++; $display("FAIL lw_done got en=%b bus_req=%b want 1 0", lsb_enable, bus_req); end
        step();
        total++; if (data_rdy !== 1'b0) begin bad++; $display("FAIL lw_pulse_width got %b want 0", data_rdy); end
    endtask

    task automatic test_load_ext();
        int cyc;
        do_req(1'b1, 1'b1, 2'd0, 32'h180, 32'h0);
        wait_rdy(cyc);
        total++; if (cyc !== 4) begin bad++; $display("FAIL lb_latency got %0d want 4", cyc); end
        total++; if (data_read !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_data got %h want ffffff80", data_read); end
        do_req(1'b1, 1'b0, 2'd0, 32'h180, 32'h0);
        wait_rdy(cyc);
        total++; if (data_read !== 32'h00000080) begin bad++; $display("FAIL lbu_data got %h want 00000080", data_read); end
        do_req(1'b1, 1'b1, 2'd1, 32'h102, 32'h0);
        wait_rdy(cyc);
        total++; if (cyc !== 5) begin bad++; $display("FAIL lh_latency got %0d want 5", cyc); end
        total++; if (data_read !== 32'hFFFF8433) begin bad++; $display("FAIL lh_data got %h want ffff8433", data_read); end
    endtask

    task automatic test_sh();
        int cyc;
        int base;
        base = wr_n;
        do_req(1'b0, 1'b0, 2'd1, 32'h204, 32'hDEADBEEF);
        step();
        total++; if (mem_wr !== 1'b1 || mem_a !== 32'h204 || mem_dout !== 8'hEF) begin bad++; $display("FAIL sh_b0 got wr=%b a=%h d=%h want 1 204 ef", mem_wr, mem_a, mem_dout); end
        step();
        total++; if (mem_wr !== 1'b1 || mem_a !== 32'h205 || mem_dout !== 8'hBE) begin bad++; $display("FAIL sh_b1 got wr=%b a=%h d=%h want 1 205 be", mem_wr, mem_a, mem_dout); end
        step();
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL sh_wr_end got %b want 0", mem_wr); end
        wait_rdy(cyc);
        total++; if (cyc !== 1) begin bad++; $display("FAIL sh_latency got %0d want 4", cyc + 3); end
        total++; if (data_read !== 32'h0) begin bad++; $display("FAIL sh_data_read got %h want 0", data_read); end
        total++; if (wr_n - base !== 2) begin bad++; $display("FAIL sh_write_count got %0d want 2", wr_n - base); end
    endtask

    task automatic test_wrap();
        int cyc;
        do_req(1'b1, 1'b0, 2'd1, 32'hFFFFFFFF, 32'h0);
        step();
        total++; if (mem_a !== 32'hFFFFFFFF) begin bad++; $display("FAIL wrap_a0 got %h want ffffffff", mem_a); end
        step();
        total++; if (mem_a !== 32'h0) begin bad++; $display("FAIL wrap_a1 got %h want 0", mem_a); end
        wait_rdy(cyc);
        total++; if (data_read !== 32'h000000FF) begin bad++; $display("FAIL wrap_data got %h want 000000ff", data_read); end
    endtask

    task automatic test_wait_grant();
        int cyc;
        bus_grant = 1'b0;
        do_req(1'b1, 1'b0, 2'd3, 32'h100, 32'h0);
        for (int i = 0; i < 5; i++) begin
            total++; if (bus_req !== 1'b1 || lsb_enable !== 1'b0) begin bad++; $display("FAIL wait_hold i=%0d got bus_req=%b en=%b want 1 0", i, bus_req, lsb_enable); end
            if (i == 1) begin
                data_addr = 32'h180;
                lsb_flag  = 1'b1;
            end
            step();
            lsb_flag = 1'b0;
        end
        bus_grant = 1'b1;
        step();
        total++; if (mem_a !== 32'h100) begin bad++; $display("FAIL wait_start got %h want 100", mem_a); end
        wait_rdy(cyc);
        total++; if (cyc !== 6) begin bad++; $display("FAIL wait_latency got %0d want 6", cyc); end
        total++; if (data_read !== 32'h84332211) begin bad++; $display("FAIL wait_data got %h want 84332211", data_read); end
    endtask

    task automatic test_flush_read();
        int p0;
        do_req(1'b1, 1'b0, 2'd3, 32'h100, 32'h0);
        step();
        step();
        step();
        total++; if (mem_a !== 32'h102) begin bad++; $display("FAIL flr_k2 got %h want 102", mem_a); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (lsb_enable !== 1'b1 || bus_req !== 1'b0) begin bad++; $display("FAIL flr_idle got en=%b bus_req=%b want 1 0", lsb_enable, bus_req); end
        p0 = rdy_pulses;
        repeat (8) step();
        total++; if (rdy_pulses !== p0) begin bad++; $display("FAIL flr_no_rdy got %0d want %0d", rdy_pulses, p0); end
    endtask

    task automatic test_flush_write();
        int cyc;
        int base;
        base = wr_n;
        do_req(1'b0, 1'b0, 2'd3, 32'h300, 32'h04030201);
        step();
        step();
        total++; if (mem_a !== 32'h301) begin bad++; $display("FAIL flw_k1 got %h want 301", mem_a); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_rdy(cyc);
        total++; if (cyc !== 3) begin bad++; $display("FAIL flw_latency got %0d want 6", cyc + 3); end
        total++; if (wr_n - base !== 4) begin bad++; $display("FAIL flw_count got %0d want 4", wr_n - base); end
        for (int i = 0; i < 4; i++) begin
            total++; if (wlog_a[(base + i) % 64] !== 32'h300 + i || wlog_d[(base + i) % 64] !== 8'(i + 1)) begin bad++; $display("FAIL flw_byte%0d got %h/%h want %h/%h", i, wlog_a[(base + i) % 64], wlog_d[(base + i) % 64], 32'h300 + i, 8'(i + 1)); end
        end
    endtask

    task automatic test_rdy_low();
        int cyc;
        int base;
        base = wr_n;
        do_req(1'b0, 1'b0, 2'd0, 32'h500, 32'h000000A5);
        step();
        total++; if (mem_wr !== 1'b1) begin bad++; $display("FAIL rdy_wr_before got %b want 1", mem_wr); end
        rdy = 1'b0;
        #1;
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL rdy_wr_forced got %b want 0", mem_wr); end
        step();
        step();
        total++; if (mem_wr !== 1'b0 || mem_a !== 32'h500 || bus_req !== 1'b1) begin bad++; $display("FAIL rdy_hold got wr=%b a=%h req=%b want 0 500 1", mem_wr, mem_a, bus_req); end
        rdy = 1'b1;
        #1;
        total++; if (mem_wr !== 1'b1) begin bad++; $display("FAIL rdy_resume got %b want 1", mem_wr); end
        wait_rdy(cyc);
        total++; if (wr_n - base !== 1 || wlog_d[base % 64] !== 8'hA5) begin bad++; $display("FAIL rdy_writes got %0d/%h want 1/a5", wr_n - base, wlog_d[base % 64]); end
    endtask

    task automatic test_reset_midop();
        int p0;
        do_req(1'b0, 1'b0, 2'd3, 32'h400, 32'h11223344);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (mem_wr !== 1'b0 || bus_req !== 1'b0 || lsb_enable !== 1'b1) begin bad++; $display("FAIL rstmid got wr=%b req=%b en=%b want 0 0 1", mem_wr, bus_req, lsb_enable); end
        p0 = rdy_pulses;
        repeat (8) step();
        total++; if (rdy_pulses !== p0) begin bad++; $display("FAIL rstmid_no_rdy got %0d want %0d", rdy_pulses, p0); end
    endtask

    task automatic test_io();
        int cyc;
        int base;
        base = wr_n;
        io_buffer_full = 1'b1;
        do_req(1'b0, 1'b0, 2'd0, 32'h30000, 32'h0000005A);
        step();
`ifdef LSB_MEM_IO_STALL_EN
        for (int i = 0; i < 3; i++) begin
            total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL io_stall i=%0d got %b want 0", i, mem_wr); end
            if (i < 2) step();
        end
        io_buffer_full = 1'b0;
        #1;
        total++; if (mem_wr !== 1'b1) begin bad++; $display("FAIL io_resume got %b want 1", mem_wr); end
`else
        total++; if (mem_wr !== 1'b1) begin bad++; $display("FAIL io_nostall got %b want 1", mem_wr); end
        io_buffer_full = 1'b0;
`endif
        wait_rdy(cyc);
        total++; if (wr_n - base !== 1) begin bad++; $display("FAIL io_count got %0d want 1", wr_n - base); end
        total++; if (wlog_a[base % 64] !== 32'h30000 || wlog_d[base % 64] !== 8'h5A) begin bad++; $display("FAIL io_write got %h/%h want 30000/5a", wlog_a[base % 64], wlog_d[base % 64]); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_sh();
        test_wrap();
        test_wait_grant();
        test_flush_read();
        test_flush_write();
        test_rdy_low();
        test_reset_midop();
        test_io();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
